oprand_mux_rr: RTL and testbench

- N-source operand selector with a registered output stage and a valid/ready handshake on every source and on the output.
- Two selection modes:
  - fixed: an external select picks the source;
  - round-robin: fair arbitration among the valid sources.
- Sits between operand producers (activation buffer, weight/ternary decode, partial-sum readback) and the CiM macro input port.
- Generalises the 2:1 combinational operand mux to N inputs with backpressure and a 1-cycle pipeline.

---
 rtl/oprand_mux_pkg.sv | 18 +
 rtl/rr_prio_enc.sv | 40 ++++
 rtl/oprand_mux_rr.sv | 149 ++++++++++++++
 tb/tb_oprand_mux_rr.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/oprand_mux_pkg.sv
// ---------------------------------------------------------------------------
// oprand_mux_pkg
//   Shared definitions for the N-source operand selector.
//   - MODE_FIXED / MODE_RR : encodings of the 'mode' input
//   - sel_width(n)         : width of a source index, clog2(n) but never 0
// ---------------------------------------------------------------------------
package oprand_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    function automatic int sel_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rr_prio_enc.sv
// ---------------------------------------------------------------------------
// rr_prio_enc
//   Rotating priority encoder. It finds the first set bit of req, scanning
//   from index ptr upward and wrapping at NUM_SRC. The module is purely
//   combinational.
//   Ports:
//     req     in  NUM_SRC  request vector
//     ptr     in  SEL_W    highest-priority index (must be < NUM_SRC)
//     gnt_idx out SEL_W    granted index (0 when gnt_vld=0)
//     gnt_vld out 1        at least one request present
// ---------------------------------------------------------------------------
module rr_prio_enc #(
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = 2
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic [SEL_W-1:0]   gnt_idx,
    output logic               gnt_vld
);

    always_comb begin
        int s;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        // Walk the offsets from farthest to nearest. The last hit
        // overwrites the earlier ones, so the hit closest to ptr wins.
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            s = int'(ptr) + k;
            if (s >= NUM_SRC) begin
                s = s - NUM_SRC;
            end
            if (req[s]) begin
                gnt_idx = SEL_W'(s);
                gnt_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/oprand_mux_rr.sv
// ---------------------------------------------------------------------------
// oprand_mux_rr
//   N-source operand selector with a single registered output stage and
//   a valid/ready handshake on every source and on the output.
//   The selector has two modes: a fixed external select, or round-robin
//   arbitration among the valid sources.
//   Ports:
//     clk, rst     clock; synchronous active-high reset
//     mode         0 = fixed select, 1 = round-robin
//     sel_fixed    source index used in fixed mode
//     src_data     packed operands, source i at [i*WIDTH +: WIDTH]
//     src_valid    per-source valid
//     src_ready    per-source ready (combinational)
//     out_data     registered selected operand
//     out_src      index of the source that produced out_data
//     out_valid    output valid
//     out_ready    downstream ready
//     stall_cnt    (only with OPRAND_MUX_RR_STAT_EN) saturating count of
//                  cycles with out_valid=1 and out_ready=0
//   Optional feature macro: OPRAND_MUX_RR_STAT_EN
// ---------------------------------------------------------------------------
module oprand_mux_rr
    import oprand_mux_pkg::*;
#(
    parameter  int WIDTH   = 32,
    parameter  int NUM_SRC = 4,
    localparam int SEL_W   = sel_width(NUM_SRC)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel_fixed,
    input  logic [NUM_SRC*WIDTH-1:0] src_data,
    input  logic [NUM_SRC-1:0]       src_valid,
    output logic [NUM_SRC-1:0]       src_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [SEL_W-1:0]         out_src,
    output logic                     out_valid,
    input  logic                     out_ready
`ifdef OPRAND_MUX_RR_STAT_EN
    ,
    output logic [31:0]              stall_cnt
`endif
);

    logic [WIDTH-1:0] out_data_reg;
    logic [SEL_W-1:0] out_src_reg;
    logic             out_valid_reg;
    logic [SEL_W-1:0] rr_ptr_reg;
    logic [SEL_W-1:0] rr_ptr_next;

    logic             load_en;
    logic [SEL_W-1:0] rr_idx;
    logic             rr_vld;
    logic             fix_vld;
    logic [SEL_W-1:0] gnt;
    logic             grant_valid;
    logic [WIDTH-1:0] gnt_data;
    logic [WIDTH-1:0] src_arr [NUM_SRC];

    // The register is free whenever it is empty or is being drained now.
    assign load_en = ~out_valid_reg | out_ready;

    rr_prio_enc #(
        .NUM_SRC (NUM_SRC),
        .SEL_W   (SEL_W)
    ) u_rr_prio_enc (
        .req     (src_valid),
        .ptr     (rr_ptr_reg),
        .gnt_idx (rr_idx),
        .gnt_vld (rr_vld)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign src_arr[gi]   = src_data[gi*WIDTH +: WIDTH];
            assign src_ready[gi] = load_en & grant_valid & (gnt == SEL_W'(gi));
        end
    endgenerate

    // Fixed mode matches sel_fixed against each legal index. An
    // out-of-range select matches nothing, so it never grants.
    always_comb begin
        fix_vld = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (sel_fixed == SEL_W'(i)) begin
                fix_vld = src_valid[i];
            end
        end
    end

    assign gnt         = (mode == MODE_RR) ? rr_idx : sel_fixed;
    assign grant_valid = (mode == MODE_RR) ? rr_vld : fix_vld;

    // Select the data with a compare loop, not a direct array index, so
    // that an out-of-range gnt never reads past src_arr.
    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (gnt == SEL_W'(i)) begin
                gnt_data = src_arr[i];
            end
        end
    end

    assign rr_ptr_next = (gnt == SEL_W'(NUM_SRC - 1)) ? '0 : gnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_reg  <= '0;
            out_src_reg   <= '0;
            out_valid_reg <= 1'b0;
            rr_ptr_reg    <= '0;
        end else if (load_en) begin
            if (grant_valid) begin
                out_data_reg  <= gnt_data;
                out_src_reg   <= gnt;
                out_valid_reg <= 1'b1;
                if (mode == MODE_RR) begin
                    rr_ptr_reg <= rr_ptr_next;
                end
            end else begin
                // Nothing to load: go empty, but keep the last data and
                // source visible.
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_data  = out_data_reg;
    assign out_src   = out_src_reg;
    assign out_valid = out_valid_reg;

`ifdef OPRAND_MUX_RR_STAT_EN
    logic [31:0] stall_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_reg <= '0;
        end else if (out_valid_reg && !out_ready && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_oprand_mux_rr.sv
// ---------------------------------------------------------------------------
// tb_oprand_mux_rr
//   Directed bench for oprand_mux_rr. The stimulus pushes the expected
//   (data, source) pairs into a queue. A monitor pops one pair for each
//   output handshake and compares it. A second 3-source instance covers
//   the out-of-range fixed select.
// ---------------------------------------------------------------------------
module tb_oprand_mux_rr;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int SW = 2;
    localparam int N3 = 3;

    logic clk = 1'b0;
    logic rst;

    // 4-source DUT
    logic            mode;
    logic [SW-1:0]   sel_fixed;
    logic [N*W-1:0]  src_data;
    logic [N-1:0]    src_valid;
    logic [N-1:0]    src_ready;
    logic [W-1:0]    out_data;
    logic [SW-1:0]   out_src;
    logic            out_valid;
    logic            out_ready;

    // 3-source DUT
    logic            mode3;
    logic [SW-1:0]   sel3;
    logic [N3*W-1:0] data3;
    logic [N3-1:0]   valid3;
    logic [N3-1:0]   ready3;
    logic [W-1:0]    out_data3;
    logic [SW-1:0]   out_src3;
    logic            out_valid3;
    logic            out_ready3;

`ifdef OPRAND_MUX_RR_STAT_EN
    logic [31:0] stall_cnt;
    logic [31:0] stall_cnt3;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [W-1:0]  data;
        logic [SW-1:0] src;
    } exp_t;

    exp_t exp_q[$];

    logic [W-1:0] d [N];

    oprand_mux_rr #(.WIDTH(W), .NUM_SRC(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel_fixed (sel_fixed),
        .src_data  (src_data),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef OPRAND_MUX_RR_STAT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    oprand_mux_rr #(.WIDTH(W), .NUM_SRC(N3)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode3),
        .sel_fixed (sel3),
        .src_data  (data3),
        .src_valid (valid3),
        .src_ready (ready3),
        .out_data  (out_data3),
        .out_src   (out_src3),
        .out_valid (out_valid3),
        .out_ready (out_ready3)
`ifdef OPRAND_MUX_RR_STAT_EN
        ,
        .stall_cnt (stall_cnt3)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int s);
        exp_t e;
        e.data = d[s];
        e.src  = SW'(s);
        exp_q.push_back(e);
    endtask

    // Monitor: one comparison per output handshake.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            exp_t e;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL out_xfer: got data=0x%0h src=%0d expected no transfer", out_data, out_src);
            end else begin
                e = exp_q.pop_front();
                if (out_data !== e.data || out_src !== e.src) begin
                    n_bad++;
                    $display("FAIL out_xfer: got data=0x%0h src=%0d expected data=0x%0h src=%0d",
                             out_data, out_src, e.data, e.src);
                end else begin
                    $display("ok   out_xfer: data=0x%0h src=%0d", out_data, out_src);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        d[0] = 32'h1111_0000;
        d[1] = 32'hA5A5_A5A5;
        d[2] = 32'h1234_5678;
        d[3] = 32'hDEAD_BEEF;
        for (int i = 0; i < N; i++) src_data[i*W +: W] = d[i];
        for (int i = 0; i < N3; i++) data3[i*W +: W] = d[i];

        rst = 1'b1; mode = 1'b0; sel_fixed = '0; src_valid = '0; out_ready = 1'b1;
        mode3 = 1'b0; sel3 = '0; valid3 = '0; out_ready3 = 1'b1;
        step(); step();
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_data",  64'(out_data),  64'd0);
        check("reset_out_src",   64'(out_src),   64'd0);
        rst = 1'b0;

        // Fixed select 2 with all sources valid.
        mode = 1'b0; sel_fixed = 2'd2; src_valid = 4'b1111;
        #1;
        check("fixed_src_ready", 64'(src_ready), 64'b0100);
        push(2);
        step();
        src_valid = '0;
        step(); step();

        // Round-robin with all sources valid, six grants.
        mode = 1'b1; src_valid = 4'b1111;
        #1;
        check("rr_first_ready", 64'(src_ready), 64'b0001);
        push(0); push(1); push(2); push(3); push(0); push(1);
        repeat (6) step();
        src_valid = '0;
        step(); step();

        // Reset the pointer, then run round-robin on sources 1 and 3 only.
        rst = 1'b1; step(); rst = 1'b0;
        src_valid = 4'b1010;
        push(1); push(3); push(1); push(3);
        repeat (4) step();
        src_valid = '0;
        step(); step();

        // Backpressure: the pointer is 0 here, so source 0 loads.
        rst = 1'b1; step(); rst = 1'b0;
        out_ready = 1'b0; src_valid = 4'b1111;
        push(0);
        step();
        for (int i = 0; i < 3; i++) begin
            check("stall_ready", 64'(src_ready), 64'd0);
            check("stall_data",  64'(out_data),  64'(d[0]));
            check("stall_valid", 64'(out_valid), 64'd1);
            if (i < 2) step();
        end
        step();
`ifdef OPRAND_MUX_RR_STAT_EN
        check("stall_cnt", 64'(stall_cnt), 64'd3);
`endif
        // Release: source 0 drains and source 1 loads in the same cycle.
        out_ready = 1'b1;
        #1;
        check("release_ready", 64'(src_ready), 64'b0010);
        push(1);
        step();
        src_valid = '0;
        step(); step();

        // Mode switch: grant 0 and 1 in round-robin, then fixed 0 twice,
        // then round-robin resumes at source 2.
        rst = 1'b1; step(); rst = 1'b0;
        mode = 1'b1; src_valid = 4'b1111;
        push(0); push(1);
        step(); step();
        mode = 1'b0; sel_fixed = 2'd0;
        push(0); push(0);
        step(); step();
        mode = 1'b1;
        push(2);
        step();
        src_valid = '0;
        step(); step();

        // Reset mid-stream with 0xA5A5A5A5 held in the output register.
        mode = 1'b0; sel_fixed = 2'd1; src_valid = 4'b0010; out_ready = 1'b0;
        step();
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        check("pre_rst_data",  64'(out_data),  64'hA5A5_A5A5);
        src_valid = '0; rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_data",  64'(out_data),  64'd0);
        check("mid_rst_src",   64'(out_src),   64'd0);
        // rr_ptr was 3 before the reset; a grant of 0 shows it was cleared.
        mode = 1'b1; src_valid = 4'b1111; out_ready = 1'b1;
        push(0);
        step();
        src_valid = '0;
        step(); step();

        // Out-of-range fixed select on the 3-source instance.
        mode3 = 1'b0; sel3 = 2'd0; valid3 = 3'b111;
        #1;
        check("n3_sel0_ready", 64'(ready3), 64'b001);
        step();
        sel3 = 2'd3;
        #1;
        check("n3_oor_ready",  64'(ready3),     64'd0);
        check("n3_loaded",     64'(out_valid3), 64'd1);
        check("n3_data0",      64'(out_data3),  64'(d[0]));
        step();
        check("n3_oor_valid",  64'(out_valid3), 64'd0);
        check("n3_hold_src",   64'(out_src3),   64'd0);
        check("n3_hold_data",  64'(out_data3),  64'(d[0]));
        valid3 = '0;
        step();

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
